tcircuit_checker: RTL and testbench
===================================

// Module: tcircuit_checker
// PURPOSE
//  Synthesizable stimulus generator and self-checker for the two-T-flip-flop
//  sequential circuit Tcircuit (x in; y, A, B out). It drives x, resets the DUT
//  and runs a cycle-accurate internal model of the same circuit. It compares
//  the DUT's y/A/B against the model every cycle and reports pass/fail.
//  It sits beside Tcircuit on the same CLK in on-board self-test builds.
// PARAMETERS
//  N_CYCLES  16     RUN cycles per test, 1..2^CNT_W-2
//  CNT_W     8      width of cycle index and first_err
//  ERR_W     8      width of err_count (saturating)
//  SEED      8'hA5  LFSR seed for mode=1; 8'h00 is replaced by 8'h01
// PORTS
//  CLK        in   1      rising-edge clock shared with DUT
//  RST        in   1      async active-high reset
//  start      in   1      begin test; sampled only in IDLE
//  mode       in   1      0 = toggle pattern, 1 = LFSR pattern; sampled with start
//  y_dut      in   1      DUT output y
//  A_dut      in   1      DUT state bit A
//  B_dut      in   1      DUT state bit B
//  x          out  1      registered stimulus to DUT input x
//  dut_rst_n  out  1      registered active-low reset to DUT
//  busy       out  1      high in CLEAR, RUN, FINAL
//  done       out  1      one-cycle pulse in DONE
//  pass       out  1      1 = last test had zero mismatches
//  err_count  out  ERR_W  mismatch count of last/current test, saturating
//  first_err  out  CNT_W  index of first mismatch; all-ones if none
// BEHAVIOUR
//  Reset (RST=1): state IDLE; x=0, dut_rst_n=0, busy=0, done=0, pass=0,
//   err_count=0, first_err=all-ones, model A_m=B_m=0.
//   After RST falls, dut_rst_n=1 from the first edge.
//  Model, per edge while in RUN:
//   TA=x&B_m, TB=x; A_m^=TA, B_m^=TB; y_m=A_m&B_m (combinational).
//  FSM:
//   IDLE:  start=1 -> CLEAR. Latches mode.
//   CLEAR: exactly 1 cycle. dut_rst_n=0, x=0, A_m=B_m=0, idx=0, err_count=0,
//          first_err=all-ones, pass=0, LFSR=SEED. Then -> RUN.
//   RUN:   N_CYCLES cycles, idx 0..N_CYCLES-1. At each edge: compare
//          {y_dut,A_dut,B_dut} against {y_m,A_m,B_m} (pre-update values).
//          Then update the model and advance x. Last cycle -> FINAL.
//   FINAL: 1 cycle. Compare only, with idx=N_CYCLES. Then -> DONE.
//   DONE:  done=1 for 1 cycle. pass=(err_count==0), valid from the DONE
//          cycle. Then -> IDLE.
//  Stimulus (x is a register, so the DUT and model see the same value):
//   mode 0: x=0 in RUN idx 0, then x toggles each cycle (0,1,0,1,...).
//   mode 1: 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1; x=lfsr[0];
//           shifts once per RUN cycle.
//   Outside RUN, x=0.
//  Mismatch: any of the 3 bits differs -> err_count+1 (holds at 2^ERR_W-1).
//   On the first mismatch only, first_err=idx.
//  Results: pass, err_count and first_err hold from DONE until the next CLEAR.
//  Boundaries:
//   - start while busy or in DONE: ignored.
//   - RST mid-test: immediate abort to reset values; no done pulse.
//   - Simultaneous mismatch and saturation: the counter stays saturated.
//  Latency: start at edge k -> CLEAR in cycle k+1 -> done in cycle k+N_CYCLES+3.
// TESTING
//  1 Hold RST=1 -> x=0, dut_rst_n=0, busy=0, done=0, pass=0, err_count=0,
//    first_err=8'hFF.
//  2 Good Tcircuit, mode=0, N=16, 1-cycle start pulse:
//    - CLEAR 1 cycle with dut_rst_n=0.
//    - x=0,1,0,1,...; A/B go 00,00,01,01,10,10,11,11,00,...
//    - y=1 at idx 6,7,14,15.
//    - done pulses 19 cycles after start; pass=1, err_count=0, first_err=8'hFF.
//  3 Same as 2, but y_dut tied 0 -> err_count=4, first_err=6, pass=0.
//  4 Good Tcircuit, mode=1, SEED=8'hA5 -> pass=1. The x sequence must match
//    the bench's LFSR reference bit-for-bit.
//  5 Start pulse at RUN idx 3 -> ignored. RST pulse at RUN idx 5 -> IDLE with
//    reset values. A new start then runs all 16 cycles -> pass=1.
//  6 ERR_W=2, A_dut stuck at 1, mode=0 -> err_count saturates at 3,
//    first_err=0, pass=0.

Source files
------------

// File: rtl/tcircuit_checker_if.sv
// -----------------------------------------------------------------------------
// tcircuit_checker_if
//   Bundles the control, DUT-observation and result signals of the Tcircuit
//   self-checker into one port.
//
//   Parameters
//     CNT_W  width of first_err (cycle index)
//     ERR_W  width of err_count
//
//   Signals
//     start      test request, sampled only when the checker is idle
//     mode       0 = toggle stimulus, 1 = LFSR stimulus (sampled with start)
//     y_dut      Tcircuit output y
//     a_dut      Tcircuit state bit A
//     b_dut      Tcircuit state bit B
//     x          registered stimulus to Tcircuit input x
//     dut_rst_n  registered active-low reset to Tcircuit
//     busy       checker is in CLEAR, RUN or FINAL
//     done       one-cycle end-of-test pulse
//     pass       last test had zero mismatches
//     err_count  saturating mismatch count
//     first_err  index of first mismatch, all-ones if none
//
//   Modports
//     master  controller / board side: drives start, mode and the DUT outputs
//     slave   the checker itself
// -----------------------------------------------------------------------------
interface tcircuit_checker_if #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 8
);

  logic             start;
  logic             mode;
  logic             y_dut;
  logic             a_dut;
  logic             b_dut;
  logic             x;
  logic             dut_rst_n;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [CNT_W-1:0] first_err;

  modport master (
    output start, mode, y_dut, a_dut, b_dut,
    input  x, dut_rst_n, busy, done, pass, err_count, first_err
  );

  modport slave (
    input  start, mode, y_dut, a_dut, b_dut,
    output x, dut_rst_n, busy, done, pass, err_count, first_err
  );

endinterface

// File: rtl/tcircuit_checker.sv
// -----------------------------------------------------------------------------
// tcircuit_checker
//   On-board stimulus generator and checker for the two-T-flip-flop circuit
//   Tcircuit (TA = x & B, TB = x, y = A & B). On a start request it resets the
//   DUT for one cycle, drives N_CYCLES stimulus bits, and compares the DUT's
//   {y, A, B} against an internal cycle-accurate model on every edge of the
//   run plus one final compare. Results hold until the next test starts.
//
//   Parameters
//     N_CYCLES  run length, 1 .. 2^CNT_W-2
//     CNT_W     width of the cycle index and first_err
//     ERR_W     width of the saturating err_count
//     SEED      LFSR seed for mode 1 (zero is replaced by 8'h01)
//
//   Ports
//     clk  rising-edge clock, shared with the DUT
//     rst  asynchronous active-high reset
//     bus  tcircuit_checker_if slave: start/mode in, DUT outputs in,
//          x/dut_rst_n to the DUT, busy/done/pass/err_count/first_err out
// -----------------------------------------------------------------------------
module tcircuit_checker #(
  parameter int         N_CYCLES = 16,
  parameter int         CNT_W    = 8,
  parameter int         ERR_W    = 8,
  parameter logic [7:0] SEED     = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  tcircuit_checker_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_FINAL,
    S_DONE
  } state_t;

  // An all-zero seed would lock the LFSR at zero.
  localparam logic [7:0]       SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(N_CYCLES - 1);
  localparam logic [CNT_W-1:0] NO_ERR   = '1;
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           state;
  state_t           state_next;

  logic             mode_q;
  logic [CNT_W-1:0] idx;
  logic             a_m;
  logic             b_m;
  logic [7:0]       lfsr;
  logic             x_q;
  logic             dut_rst_n_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_count_q;
  logic [CNT_W-1:0] first_err_q;

  logic             y_m;
  logic             compare_en;
  logic             mismatch;
  logic             last_run;
  logic [7:0]       lfsr_next;

  // Model output is combinational from the model state, like the real circuit.
  assign y_m        = a_m & b_m;
  assign compare_en = (state == S_RUN) || (state == S_FINAL);
  assign mismatch   = {bus.y_dut, bus.a_dut, bus.b_dut} != {y_m, a_m, b_m};
  assign last_run   = (idx == IDX_LAST);

  // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1: taps at bits 7, 5, 4, 3,
  // new bit shifted in at bit 0.
  assign lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is always written with non-blocking (<=) so every
  // flop samples the pre-edge values and simulation matches the hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        bus.busy   = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        bus.busy = 1'b1;
        if (last_run) begin
          state_next = S_FINAL;
        end
      end
      S_FINAL: begin
        bus.busy   = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        bus.done   = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: stimulus, DUT reset, model and result registers
  // ---------------------------------------------------------------------------
  // The clearing work is done on the edge that enters CLEAR, so the CLEAR
  // cycle itself already shows dut_rst_n=0 and cleared results. The lfsr
  // register always holds the state for the *next* RUN index; x is the
  // registered bit for the current one, so DUT and model see the same x.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= 1'b0;
      idx         <= '0;
      a_m         <= 1'b0;
      b_m         <= 1'b0;
      lfsr        <= SEED_EFF;
      x_q         <= 1'b0;
      dut_rst_n_q <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      first_err_q <= NO_ERR;
    end else begin
      unique case (state)
        S_IDLE: begin
          // Releases the DUT reset on the first edge after rst falls.
          dut_rst_n_q <= 1'b1;
          x_q         <= 1'b0;
          if (bus.start) begin
            mode_q      <= bus.mode;
            dut_rst_n_q <= 1'b0;
            a_m         <= 1'b0;
            b_m         <= 1'b0;
            idx         <= '0;
            err_count_q <= '0;
            first_err_q <= NO_ERR;
            pass_q      <= 1'b0;
            lfsr        <= SEED_EFF;
          end
        end
        S_CLEAR: begin
          dut_rst_n_q <= 1'b1;
          if (mode_q) begin
            x_q  <= lfsr[0];
            lfsr <= lfsr_next;
          end else begin
            x_q  <= 1'b0;
          end
        end
        S_RUN: begin
          a_m <= a_m ^ (x_q & b_m);
          b_m <= b_m ^ x_q;
          idx <= idx + 1'b1;
          if (last_run) begin
            x_q <= 1'b0;
          end else if (mode_q) begin
            x_q  <= lfsr[0];
            lfsr <= lfsr_next;
          end else begin
            x_q  <= ~x_q;
          end
        end
        S_FINAL: begin
          // Includes the final compare happening on this same edge.
          pass_q <= (err_count_q == '0) && !mismatch;
        end
        default: begin
        end
      endcase

      // Compare uses the model state before this edge's update.
      if (compare_en && mismatch) begin
        if (err_count_q != ERR_MAX) begin
          err_count_q <= err_count_q + 1'b1;
        end
        if (err_count_q == '0) begin
          first_err_q <= idx;
        end
      end
    end
  end

  assign bus.x         = x_q;
  assign bus.dut_rst_n = dut_rst_n_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_count_q;
  assign bus.first_err = first_err_q;

endmodule

// File: tb/tb_tcircuit_checker.sv
// -----------------------------------------------------------------------------
// tb_tcircuit_checker
//   Two checker instances (ERR_W=8 and ERR_W=2) run side by side, each beside
//   a behavioural Tcircuit stand-in with selectable output faults. Expected
//   x sequences and results come from a reference model that treats Tcircuit
//   as a 2-bit counter of x=1 pulses and counts mismatches from that.
// -----------------------------------------------------------------------------
module tb_tcircuit_checker;

  localparam int N_CYC = 16;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  // Fault injected on both stand-ins: 0 none, 1 y stuck 0, 2 A stuck 1,
  // 3 B stuck 0, 4 A inverted at cycle fault_idx only.
  int fault     = 0;
  int fault_idx = 0;

  bit ref_x [0:N_CYC-1];
  int ref_err;
  int ref_first;

  typedef struct {
    bit mode;
    int fault;
    int fidx;
    bit exp_pass;
    int exp_err;
    int exp_first;
    bit poke_done;
  } vec_t;

  vec_t vecs [0:6];

  always #5 clk = ~clk;

  tcircuit_checker_if #(.CNT_W(8), .ERR_W(8)) bus  ();
  tcircuit_checker_if #(.CNT_W(8), .ERR_W(2)) bus2 ();

  tcircuit_checker #(.N_CYCLES(N_CYC), .CNT_W(8), .ERR_W(8), .SEED(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  tcircuit_checker #(.N_CYCLES(N_CYC), .CNT_W(8), .ERR_W(2), .SEED(8'hA5)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  assign bus2.start = bus.start;
  assign bus2.mode  = bus.mode;

  // Tcircuit stand-ins (T flip-flops, async active-low reset) with cycle count.
  logic a1, b1, a2, b2;
  int   cyc1, cyc2;

  always_ff @(posedge clk or negedge bus.dut_rst_n) begin
    if (!bus.dut_rst_n) begin
      a1 <= 1'b0; b1 <= 1'b0; cyc1 <= 0;
    end else begin
      a1 <= a1 ^ (bus.x & b1); b1 <= b1 ^ bus.x; cyc1 <= cyc1 + 1;
    end
  end

  always_ff @(posedge clk or negedge bus2.dut_rst_n) begin
    if (!bus2.dut_rst_n) begin
      a2 <= 1'b0; b2 <= 1'b0; cyc2 <= 0;
    end else begin
      a2 <= a2 ^ (bus2.x & b2); b2 <= b2 ^ bus2.x; cyc2 <= cyc2 + 1;
    end
  end

  always_comb begin
    bus.y_dut = a1 & b1;
    bus.a_dut = a1;
    bus.b_dut = b1;
    if (fault == 1) bus.y_dut = 1'b0;
    if (fault == 2) bus.a_dut = 1'b1;
    if (fault == 3) bus.b_dut = 1'b0;
    if (fault == 4 && cyc1 == fault_idx) bus.a_dut = ~a1;
  end

  always_comb begin
    bus2.y_dut = a2 & b2;
    bus2.a_dut = a2;
    bus2.b_dut = b2;
    if (fault == 1) bus2.y_dut = 1'b0;
    if (fault == 2) bus2.a_dut = 1'b1;
    if (fault == 3) bus2.b_dut = 1'b0;
    if (fault == 4 && cyc2 == fault_idx) bus2.a_dut = ~a2;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  // Reference: Tcircuit state = (number of x=1 seen so far) mod 4, A = bit 1,
  // B = bit 0, y = (state == 3). Mismatches follow from the fault type.
  task automatic ref_model(input bit m, input int f, input int fidx);
    logic [7:0] l;
    int s;
    int cnt;
    bit mis;
    l         = 8'hA5;
    s         = 0;
    cnt       = 0;
    ref_first = 255;
    for (int i = 0; i <= N_CYC; i++) begin
      if (i < N_CYC) ref_x[i] = m ? l[0] : bit'(i % 2);
      case (f)
        1:       mis = (s == 3);
        2:       mis = (s < 2);
        3:       mis = (s % 2 == 1);
        4:       mis = (i == fidx);
        default: mis = 1'b0;
      endcase
      if (mis) begin
        if (ref_first == 255) ref_first = i;
        cnt++;
      end
      if (i < N_CYC) begin
        s = (s + int'(ref_x[i])) % 4;
        if (m) l = lfsr_step(l);
      end
    end
    ref_err = cnt;
  endtask

  task automatic run_test(input bit m, input int f, input int fidx, input bit exp_pass,
                          input int exp_err, input int exp_first, input bit poke_done);
    int sat2;
    ref_model(m, f, fidx);
    sat2      = (exp_err > 3) ? 3 : exp_err;
    fault     = f;
    fault_idx = fidx;
    bus.mode  = m;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("clear_busy_done", {bus.busy, bus.done}, 2'b10);
    check("clear_dut_rst_n", bus.dut_rst_n, 1'b0);
    check("clear_x", bus.x, 1'b0);
    check("clear_results", {bus.pass, bus.err_count, bus.first_err}, {1'b0, 8'h00, 8'hFF});
    for (int i = 0; i < N_CYC; i++) begin
      @(negedge clk);
      check($sformatf("run_x[%0d]", i), bus.x, ref_x[i]);
      check($sformatf("run_ctl[%0d]", i), {bus.busy, bus.done, bus.dut_rst_n}, 3'b101);
    end
    @(negedge clk);
    check("final_ctl", {bus.busy, bus.done, bus.x}, 3'b100);
    @(negedge clk);
    check("done_pulse", {bus.busy, bus.done}, 2'b01);
    check("pass", bus.pass, exp_pass);
    check("err_count", bus.err_count, exp_err);
    check("first_err", bus.first_err, exp_first);
    check("sat_err_count", bus2.err_count, sat2);
    check("sat_first_err", bus2.first_err, exp_first);
    check("sat_pass", bus2.pass, exp_pass);
    if (poke_done) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("after_done_idle", {bus.busy, bus.done, bus.x}, 3'b000);
    check("results_hold", {bus.pass, bus.err_count, bus.first_err},
          {exp_pass, 8'(exp_err), 8'(exp_first)});
    fault = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 0, 0,  1, 0, 255, 0};
    vecs[1] = '{0, 1, 0,  0, 4, 6,   0};
    vecs[2] = '{1, 0, 0,  1, 0, 255, 1};
    vecs[3] = '{0, 2, 0,  0, 9, 0,   0};
    vecs[4] = '{0, 3, 0,  0, 8, 2,   0};
    vecs[5] = '{0, 4, 16, 0, 1, 16,  0};
    vecs[6] = '{1, 4, 0,  0, 1, 0,   0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctl", {bus.x, bus.dut_rst_n, bus.busy, bus.done}, 4'b0000);
    check("reset_results", {bus.pass, bus.err_count, bus.first_err}, {1'b0, 8'h00, 8'hFF});
    check("reset_results_w2", {bus2.pass, bus2.err_count}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_dut_rst_n", {bus.dut_rst_n, bus.busy}, 2'b10);

    for (int v = 0; v < 7; v++) begin
      run_test(vecs[v].mode, vecs[v].fault, vecs[v].fidx, vecs[v].exp_pass,
               vecs[v].exp_err, vecs[v].exp_first, vecs[v].poke_done);
    end

    // Start while running is ignored; reset mid-run aborts to reset values.
    ref_model(0, 0, 0);
    bus.mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_midrun_start", {bus.busy, bus.done}, 2'b10);
    check("x_after_midrun_start", bus.x, ref_x[4]);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ctl", {bus.x, bus.dut_rst_n, bus.busy, bus.done}, 4'b0000);
    check("abort_results", {bus.pass, bus.err_count, bus.first_err}, {1'b0, 8'h00, 8'hFF});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_release", {bus.dut_rst_n, bus.busy, bus.done}, 3'b100);
    run_test(0, 0, 0, 1, 0, 255, 0);

    // Randomized runs against the reference model.
    for (int r = 0; r < 10; r++) begin
      bit m;
      int f;
      int fi;
      m  = bit'($urandom_range(0, 1));
      f  = int'($urandom_range(0, 4));
      fi = int'($urandom_range(0, N_CYC));
      ref_model(m, f, fi);
      run_test(m, f, fi, ref_err == 0, ref_err, ref_first, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
